// File: rtl/fifo_halfword_unpacker.sv
// Read-side consumer for the word FIFO: pulls 32-bit words and streams them as 16-bit halfwords per counted burst.
// Optional build macro FIFO_UNPACK_HI_FIRST_EN emits the upper halfword of each word first.
module fifo_halfword_unpacker #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] hw_count_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rd_en_o,
  input  logic [31:0]          fifo_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [15:0]          out_data_o,
  output logic                 out_last_o
);

`ifdef FIFO_UNPACK_HI_FIRST_EN
  localparam logic HI_FIRST = 1'b1;
`else
  localparam logic HI_FIRST = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] hw_rem;
  logic [CNT_WIDTH:0]   wd_rem;
  logic [CNT_WIDTH:0]   wd_init;
  logic [31:0]          word_buf [2];
  logic                 head;
  logic [1:0]           occ;
  logic                 inflight;
  logic                 sel;
  logic                 busy_q;
  logic                 done_q;

  logic                 run;
  logic [2:0]           fill;
  logic                 rd_en;
  logic                 valid;
  logic                 last_hw;
  logic                 hs;
  logic                 pop;
  logic                 tail;
  logic [31:0]          head_word;

  // One extra bit so that the maximum halfword count cannot wrap the word count
  assign wd_init   = ({1'b0, hw_count_i} + (CNT_WIDTH+1)'(1)) >> 1;

  assign run       = (state == RUN);
  assign fill      = {1'b0, occ} + {2'b00, inflight};
  assign rd_en     = run & ~fifo_empty_i & (wd_rem != '0) & (fill < 3'd2);
  assign valid     = run & (occ != 2'd0);
  assign last_hw   = (hw_rem == CNT_WIDTH'(1));
  assign hs        = valid & out_ready_i;
  assign pop       = hs & (sel | last_hw);
  assign tail      = head ^ occ[0];
  assign head_word = word_buf[head];

  assign fifo_rd_en_o = rd_en;
  assign out_valid_o  = valid;
  assign out_last_o   = valid & last_hw;
  assign out_data_o   = !valid             ? 16'h0000 :
                        (sel ^ HI_FIRST)   ? head_word[31:16] : head_word[15:0];
  assign busy_o       = busy_q;
  assign done_o       = done_q;

  // Word storage: written one cycle after the read that fetched it
  always_ff @(posedge clk_i) begin
    if (inflight) word_buf[tail] <= fifo_data_i;
  end

  // Control: burst FSM, counters, buffer pointers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      hw_rem   <= '0;
      wd_rem   <= '0;
      head     <= 1'b0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      sel      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (rd_en) wd_rem <= wd_rem - (CNT_WIDTH+1)'(1);

      case ({inflight, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      if (pop) head <= ~head;

      if (hs) begin
        hw_rem <= hw_rem - CNT_WIDTH'(1);
        sel    <= ~pop;
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            hw_rem <= hw_count_i;
            wd_rem <= wd_init;
            sel    <= 1'b0;
            occ    <= 2'd0;
            head   <= 1'b0;
            busy_q <= 1'b1;
            if (hw_count_i != '0) begin
              state <= RUN;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs && last_hw) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_halfword_unpacker.sv
// Scoreboard bench for fifo_halfword_unpacker: FIFO model with one-cycle read latency,
// randomized ready/stall, expected halfwords derived from the words queued for each burst.
module tb_fifo_halfword_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] hw_count = 16'd0;
  logic        busy, done, fifo_rd_en, fifo_empty;
  logic [31:0] fifo_data = 32'd0;
  logic        out_valid, out_last;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;

  logic [31:0] mem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          mptr = 0;
  int          reads = 0;
  logic        stall_force = 1'b0;
  logic        stall_rand = 1'b0;
  int          rmode = 0;
  int          smode = 0;

  logic [16:0] exp_q[$];
  int          exp_reads = 0;
  int          r0 = 0;
  int          hs_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  assign fifo_empty = stall_force | stall_rand | (rd_ptr == wr_ptr);

  fifo_halfword_unpacker #(.CNT_WIDTH(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .hw_count_i  (hw_count),
    .busy_o      (busy),
    .done_o      (done),
    .fifo_empty_i(fifo_empty),
    .fifo_rd_en_o(fifo_rd_en),
    .fifo_data_i (fifo_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last)
  );

  // FIFO read side: registered data one cycle after rd_en
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr % 1024];
      rd_ptr    <= rd_ptr + 1;
      reads     <= reads + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, need 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr % 1024] = w;
    wr_ptr++;
  endtask

  // Reference: a burst of n halfwords consumes the next ceil(n/2) queued words in order
  task automatic model_burst(input int n);
    int nw;
    nw = (n + 1) / 2;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] wd;
      logic [15:0] a, b;
      wd = mem[(mptr + w) % 1024];
`ifdef FIFO_UNPACK_HI_FIRST_EN
      a = wd[31:16]; b = wd[15:0];
`else
      a = wd[15:0];  b = wd[31:16];
`endif
      exp_q.push_back({(2*w + 1 == n) ? 1'b1 : 1'b0, a});
      if (2*w + 1 < n) exp_q.push_back({(2*w + 2 == n) ? 1'b1 : 1'b0, b});
    end
    mptr += nw;
    exp_reads = nw;
  endtask

  task automatic start_burst(input int n);
    model_burst(n);
    r0 = reads;
    hw_count = 16'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("burst_reads", reads - r0, exp_reads);
      chk("exp_drained", exp_q.size(), 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    mptr = rd_ptr;
    @(posedge clk); #1;
  endtask

  // Ready and random-stall driver
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      stall_rand = (smode != 0) && ($urandom_range(0, 3) == 0);
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks hold and done timing
  initial begin
    logic        hold_v = 1'b0;
    logic        exp_done = 1'b0;
    logic [15:0] hold_d = 16'd0;
    logic        hold_l = 1'b0;
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v   = 1'b0;
        exp_done = 1'b0;
      end else begin
        if (exp_done) begin
          chk("done_after_last", 32'(done), 1);
          chk("busy_in_done", 32'(busy), 1);
          exp_done = 1'b0;
        end
        if (fifo_rd_en) chk("rd_en_while_empty", 32'(fifo_empty), 0);
        if (hold_v) begin
          chk("hold_valid", 32'(out_valid), 1);
          chk("hold_data", 32'(out_data), 32'(hold_d));
          chk("hold_last", 32'(out_last), 32'(hold_l));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_output", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("hw_data", 32'(out_data), 32'(e[15:0]));
            chk("hw_last", 32'(out_last), 32'(e[16]));
            if (e[16]) exp_done = 1'b1;
          end
          hs_cnt++;
        end
        hold_v = out_valid & ~out_ready;
        hold_d = out_data;
        hold_l = out_last;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    bit reached;
    do_reset();

    // Basic 4-halfword burst with latency checks
    push_word(32'h2222_1111);
    push_word(32'h4444_3333);
    start_burst(4);
    @(negedge clk);
    chk("c1_busy", 32'(busy), 1);
    chk("c1_rd_en", 32'(fifo_rd_en), 1);
    chk("c1_valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("c2_valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("c3_valid", 32'(out_valid), 1);
    wait_done(100);

    // Odd count: final upper/lower half dropped
    push_word(32'h2222_1111);
    push_word(32'h4444_3333);
    start_burst(3);
    wait_done(100);

    // Zero count
    push_word(32'hAAAA_5555);
    start_burst(0);
    @(negedge clk);
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 1);
    chk("zero_rd_en", 32'(fifo_rd_en), 0);
    chk("zero_valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("zero_idle_busy", 32'(busy), 0);
    chk("zero_idle_done", 32'(done), 0);
    chk("zero_reads", reads - r0, 0);
    @(posedge clk); #1;

    // Backpressure toggling plus a 5-cycle FIFO stall
    for (int i = 0; i < 4; i++) push_word($urandom);
    rmode = 1;
    start_burst(8);
    repeat (3) @(posedge clk);
    #1 stall_force = 1'b1;
    repeat (5) @(posedge clk);
    #1 stall_force = 1'b0;
    wait_done(200);
    rmode = 0;

    // Asynchronous reset after 3 halfwords, then resume from remaining words
    for (int i = 0; i < 5; i++) push_word($urandom);
    target = hs_cnt + 3;
    start_burst(8);
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(posedge clk);
      if (hs_cnt >= target) reached = 1'b1;
    end
    chk("three_hs_before_reset", 32'(reached), 1);
    #3;
    do_reset();
    start_burst(2);
    wait_done(100);

    // Start pulsed while busy is ignored
    for (int i = 0; i < 4; i++) push_word($urandom);
    start_burst(6);
    repeat (2) @(posedge clk);
    #1;
    hw_count = 16'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_ignored_start", 32'(busy), 1);
    wait_done(100);

    // Back-to-back bursts: second start in the cycle after done
    push_word(32'h1357_2468);
    push_word(32'h9BDF_ACE0);
    start_burst(2);
    wait_done(100);
    start_burst(2);
    @(negedge clk);
    chk("b2b_accepted", 32'(busy), 1);
    wait_done(100);

    // Randomized bursts with random ready and stalls
    rmode = 2;
    smode = 1;
    for (int k = 0; k < 25; k++) begin
      int n;
      n = $urandom_range(0, 14);
      for (int i = 0; i < (n + 1) / 2 + int'($urandom_range(0, 2)); i++) push_word($urandom);
      start_burst(n);
      wait_done(400);
    end
    rmode = 0;
    smode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
